// File: rtl/fpu_mul_result_stage.sv
// fpu_mul_result_stage
// Output stage behind the combinational double-precision multiplier. Products
// and their {exception, overflow, underflow} flags are held in a small
// first-word-fall-through FIFO with valid/ready on both sides. Sticky status
// bits and saturating overflow/underflow event counters are kept alongside.
module fpu_mul_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_result,
  input  logic                       in_exception,
  input  logic                       in_overflow,
  input  logic                       in_underflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_result,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 sticky_flags,
  input  logic                       flag_clr,
  output logic [CNT_W-1:0]           ovf_count,
  output logic [CNT_W-1:0]           unf_count,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = 67;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] base,
                                               input logic              inc);
    logic [CNT_W-1:0] res;
    if (inc && (base != {CNT_W{1'b1}})) begin
      res = base + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = base;
    end
    return res;
  endfunction

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [2:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] unf_q, unf_d;
  logic             push_s;
  logic             pop_s;
  logic [2:0]       in_flags_s;

  // Handshake qualification; ready is independent of out_ready so a full
  // FIFO never accepts even when it is being drained in the same cycle.
  always_comb begin
    in_flags_s = {in_exception, in_overflow, in_underflow};
    in_ready   = rst_n & (occ_q != OCC_W'(DEPTH));
    out_valid  = (occ_q != {OCC_W{1'b0}});
    push_s     = in_valid & in_ready;
    pop_s      = out_valid & out_ready;
  end

  // Next-state for pointers, occupancy, sticky bits and event counters.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    // A new flag wins over a simultaneous clear.
    sticky_d = (flag_clr ? 3'b000 : sticky_q) | (push_s ? in_flags_s : 3'b000);
    ovf_d    = sat_inc(flag_clr ? {CNT_W{1'b0}} : ovf_q, push_s & in_overflow);
    unf_d    = sat_inc(flag_clr ? {CNT_W{1'b0}} : unf_q, push_s & in_underflow);
  end

  // State registers with synchronous active-low reset; reset also scrubs
  // the storage so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      sticky_q <= 3'b000;
      ovf_q    <= {CNT_W{1'b0}};
      unf_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= {in_flags_s, in_result};
      end
    end
  end

  // Head entry falls through straight from the storage registers.
  always_comb begin
    out_result   = mem_q[rd_ptr_q][63:0];
    out_flags    = mem_q[rd_ptr_q][66:64];
    sticky_flags = sticky_q;
    ovf_count    = ovf_q;
    unf_count    = unf_q;
    occupancy    = occ_q;
  end

endmodule

// File: tb/tb_fpu_mul_result_stage.sv
// Testbench for fpu_mul_result_stage: directed steps with a queue scoreboard
// and a reference model of occupancy, sticky bits and counters.
module tb_fpu_mul_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_result;
  logic        in_exception, in_overflow, in_underflow;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [2:0]  out_flags, sticky_flags;
  logic        flag_clr;
  logic [15:0] ovf_count, unf_count;
  logic [2:0]  occupancy;

  // small-counter instance used for the saturation boundary
  logic        s_in_valid, s_in_ready, s_out_valid, s_overflow;
  logic [63:0] s_out_result;
  logic [2:0]  s_out_flags, s_sticky;
  logic [2:0]  s_ovf_count, s_unf_count;
  logic [2:0]  s_occupancy;

  always #5 clk = ~clk;

  fpu_mul_result_stage #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_exception(in_exception),
    .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .sticky_flags(sticky_flags), .flag_clr(flag_clr),
    .ovf_count(ovf_count), .unf_count(unf_count), .occupancy(occupancy)
  );

  fpu_mul_result_stage #(.DEPTH(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_result(64'h3FF0_0000_0000_0000), .in_exception(1'b0),
    .in_overflow(s_overflow), .in_underflow(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_result(s_out_result),
    .out_flags(s_out_flags), .sticky_flags(s_sticky), .flag_clr(1'b0),
    .ovf_count(s_ovf_count), .unf_count(s_unf_count), .occupancy(s_occupancy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [66:0] sb_q[$];
  logic [2:0]  m_sticky;
  int          m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_sticky = 3'b000;
    m_ovf    = 0;
    m_unf    = 0;
  endtask

  // One clock: compare state against the model, then apply this cycle's
  // handshakes to the model and let the edge happen.
  task automatic tick();
    logic [66:0] exp_e;
    logic [2:0]  fl;
    bit          mpush, mpop;
    @(negedge clk);
    chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
    chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(rst_n && (sb_q.size() != 4)));
    chk("sticky",    64'(sticky_flags), 64'(m_sticky));
    chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
    chk("unf_count", 64'(unf_count), 64'(m_unf));
    if (!rst_n) begin
      model_clear();
    end else begin
      fl    = {in_exception, in_overflow, in_underflow};
      mpop  = out_ready && (sb_q.size() != 0);
      mpush = in_valid && (sb_q.size() != 4);
      if (mpop) begin
        exp_e = sb_q.pop_front();
        chk("out_result", out_result, exp_e[63:0]);
        chk("out_flags",  64'(out_flags), 64'(exp_e[66:64]));
      end
      if (mpush) sb_q.push_back({fl, in_result});
      m_sticky = (flag_clr ? 3'b000 : m_sticky) | (mpush ? fl : 3'b000);
      if (flag_clr) begin m_ovf = 0; m_unf = 0; end
      if (mpush && fl[1] && m_ovf < 65535) m_ovf++;
      if (mpush && fl[0] && m_unf < 65535) m_unf++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [2:0] f);
    in_valid     = v;
    in_result    = d;
    in_exception = f[2];
    in_overflow  = f[1];
    in_underflow = f[0];
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    s_in_valid = 1'b0; s_overflow = 1'b0;
    drive(1'b0, 64'h0, 3'b000);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    tick();                                  // reset values, in_ready low
    chk("reset_out_result", out_result, 64'h0);
    chk("reset_out_flags", 64'(out_flags), 64'h0);
    rst_n = 1'b1;

    // 1: single entry, one-cycle latency, then pop
    drive(1'b1, 64'h4000_0000_0000_0000, 3'b000);
    tick();
    drive(1'b0, 64'h0, 3'b000);
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_head", out_result, 64'h4000_0000_0000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    // 2: fill to 4 with a 5th attempt refused, drain, then wrap the pointers
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'hA000_0000_0000_0000 + 64'(i), 3'(i));
      tick();
    end
    chk("t2_full_ready", 64'(in_ready), 64'h0);
    drive(1'b0, 64'h0, 3'b000);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {$urandom(), $urandom()}, 3'($urandom_range(0, 7)));
      tick();
    end
    drive(1'b0, 64'h0, 3'b000);
    out_ready = 1'b1;
    repeat (5) tick();

    // 3: occupancy 2, simultaneous push and pop for 10 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'hC000_0000_0000_0000 + 64'(i), 3'b100);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, {$urandom(), $urandom()}, 3'($urandom_range(0, 7)));
      tick();
      chk("t3_occ", 64'(occupancy), 64'h2);
    end
    drive(1'b0, 64'h0, 3'b000);
    repeat (3) tick();

    // 4: overflow counting, clear with a simultaneous counted push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h7FF0_0000_0000_0000, 3'b010);
      tick();
    end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    drive(1'b0, 64'h0, 3'b000);
    tick();
    chk("t4_ovf_after_clr", 64'(ovf_count), 64'h1);
    chk("t4_sticky_after_clr", 64'(sticky_flags), 64'h2);
    repeat (2) tick();

    // 4b: saturation on the narrow-counter instance (max 7)
    s_in_valid = 1'b1; s_overflow = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("t4_narrow_count6", 64'(s_ovf_count), 64'h6);
    repeat (4) begin @(posedge clk); #1; end
    chk("t4_narrow_sat", 64'(s_ovf_count), 64'h7);
    s_in_valid = 1'b0; s_overflow = 1'b0;

    // 5: reset with entries in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hBEEF_0000_0000_0000 + 64'(i), 3'b001);
      tick();
    end
    drive(1'b0, 64'h0, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("t5_ready_in_reset", 64'(in_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_occ", 64'(occupancy), 64'h0);
    chk("t5_out_valid", 64'(out_valid), 64'h0);
    chk("t5_sticky", 64'(sticky_flags), 64'h0);
    chk("t5_ready_after", 64'(in_ready), 64'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
